// File: rtl/approx_avg_stream_pkg.sv
// Shared constants and width helpers for the approximate-averaging stream filter.
package approx_avg_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Running window sum: WIN full-scale samples plus one bit of margin.
  function automatic int calc_sum_w(input int data_w, input int win);
    return data_w + clog2(win) + 1;
  endfunction

  // Stage-2 accumulator: sum + WIN*appr, at most twice the largest window sum.
  function automatic int calc_acc_w(input int data_w, input int win);
    return data_w + clog2(win) + 2;
  endfunction

  // Fill counter must be able to hold the value WIN itself.
  function automatic int calc_cnt_w(input int win);
    return clog2(win + 1);
  endfunction

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_WIN          = 9;
  localparam int DEF_SH           = 3;
  localparam int DEF_EMIT_PARTIAL = 0;

  localparam int SUM_W = calc_sum_w(DEF_DATA_W, DEF_WIN);
  localparam int ACC_W = calc_acc_w(DEF_DATA_W, DEF_WIN);
  localparam int CNT_W = calc_cnt_w(DEF_WIN);
  localparam int OUT_W = DEF_DATA_W + 2;

endpackage

// File: rtl/approx_avg_stream_if.sv
// Sample/result bus of the approximate-averaging filter.
//
// Handshake: valid-only, no backpressure. The producer asserts in_valid for
// exactly the cycles whose X must be consumed; every such cycle is taken at
// the next rising edge. flush clears the window on the same edge (and is
// applied before a simultaneous sample). out_valid marks each cycle in which
// Y carries a fresh result; the consumer must take it in that cycle. Y holds
// its previous value whenever out_valid is low.
interface approx_avg_stream_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic [DATA_W-1:0] X;
  logic              flush;
  logic              out_valid;
  logic [DATA_W+1:0] Y;

  modport master (output in_valid, X, flush, input out_valid, Y);
  modport slave  (input in_valid, X, flush, output out_valid, Y);
endinterface

// File: rtl/approx_avg_stream_sel.sv
// Combinational selector: largest window tap not exceeding avg.
// Leaves whose tap is above avg are masked to zero, then a balanced max tree
// reduces them. A qualifying tap always exists (the minimum never exceeds the
// mean), so a zero from masking can never win wrongly.
module approx_sel
  import approx_avg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 9,
  parameter int AVG_W  = 13
) (
  input  logic [DATA_W-1:0] taps [WIN],
  input  logic [AVG_W-1:0]  avg,
  output logic [DATA_W-1:0] appr
);

  localparam int NP = 1 << clog2(WIN);

  // Heap-ordered max tree: node k has children 2k and 2k+1, leaves at NP..2NP-1.
  always_comb begin : tree
    logic [DATA_W-1:0] node [1:2*NP-1];
    for (int k = 1; k < 2 * NP; k++) node[k] = '0;
    for (int i = 0; i < WIN; i++)
      node[NP + i] = (AVG_W'(taps[i]) <= avg) ? taps[i] : '0;
    for (int k = NP - 1; k >= 1; k--)
      node[k] = (node[2*k] >= node[2*k+1]) ? node[2*k] : node[2*k+1];
    appr = node[1];
  end

endmodule

// File: rtl/approx_avg_stream.sv
// Streaming approximate-averaging filter.
// Stage 0: sliding window + running sum + fill count.
// Stage 1: avg = floor(sum/WIN), appr = largest tap <= avg.
// Stage 2: Y = (sum + WIN*appr) >> SH.
// Optional build macro APPROX_AVG_ROUND_EN: round half up before the shift and
// saturate Y to its full-scale value; without it the shift truncates.
module approx_avg_stream
  import approx_avg_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int WIN          = DEF_WIN,
  parameter int SH           = DEF_SH,
  parameter int EMIT_PARTIAL = DEF_EMIT_PARTIAL
) (
  input logic                 clk,
  input logic                 reset,
  approx_avg_stream_if.slave  bus
);

  localparam int SW = calc_sum_w(DATA_W, WIN);
  localparam int AW = calc_acc_w(DATA_W, WIN);
  localparam int CW = calc_cnt_w(WIN);
  localparam int OW = DATA_W + 2;

  // ---------------- stage 0 ----------------
  logic [DATA_W-1:0] taps [WIN];
  logic [SW-1:0]     sum_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_base;
  logic [CW-1:0]     cnt_nxt;
  logic              v0_q;

  // Next fill count: flush restarts from zero, a sample adds one up to WIN.
  always_comb begin
    cnt_base = bus.flush ? '0 : cnt_q;
    cnt_nxt  = cnt_base;
    if (bus.in_valid && (cnt_base != CW'(WIN))) cnt_nxt = cnt_base + 1'b1;
  end

  // Window shift, running sum and gated valid for the sample just taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) taps[i] <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      v0_q  <= 1'b0;
    end else begin
      v0_q  <= bus.in_valid && ((EMIT_PARTIAL != 0) || (cnt_nxt == CW'(WIN)));
      cnt_q <= cnt_nxt;
      if (bus.flush) begin
        for (int i = 1; i < WIN; i++) taps[i] <= '0;
        taps[0] <= bus.in_valid ? bus.X : '0;
        sum_q   <= bus.in_valid ? SW'(bus.X) : '0;
      end else if (bus.in_valid) begin
        for (int i = 1; i < WIN; i++) taps[i] <= taps[i-1];
        taps[0] <= bus.X;
        sum_q   <= sum_q - SW'(taps[WIN-1]) + SW'(bus.X);
      end
    end
  end

  // ---------------- stage 1 ----------------
  logic [SW-1:0]     avg;
  logic [DATA_W-1:0] appr_c;
  logic              s1_v;
  logic [DATA_W-1:0] s1_appr;
  logic [SW-1:0]     s1_sum;

  assign avg = sum_q / SW'(WIN);

  approx_sel #(
    .DATA_W (DATA_W),
    .WIN    (WIN),
    .AVG_W  (SW)
  ) u_sel (
    .taps (taps),
    .avg  (avg),
    .appr (appr_c)
  );

  // Capture the selection and the sum it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v    <= 1'b0;
      s1_appr <= '0;
      s1_sum  <= '0;
    end else begin
      s1_v <= v0_q;
      if (v0_q) begin
        s1_appr <= appr_c;
        s1_sum  <= sum_q;
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic [AW-1:0] acc;
  logic [OW-1:0] y_nxt;

`ifdef APPROX_AVG_ROUND_EN
  localparam int            RW      = AW + 1;
  localparam int            HALF    = 1 << (SH - 1);
  localparam logic [OW-1:0] OUT_MAX = '1;
  logic [RW-1:0] rnd;
`endif

  // Combine sum and WIN*appr, then scale down to the output width.
  always_comb begin
    acc = AW'(s1_sum) + AW'(WIN) * AW'(s1_appr);
`ifdef APPROX_AVG_ROUND_EN
    rnd   = (RW'(acc) + RW'(HALF)) >> SH;
    y_nxt = (rnd > RW'(OUT_MAX)) ? OUT_MAX : OW'(rnd);
`else
    y_nxt = OW'(acc >> SH);
`endif
  end

  // Output register; Y only moves with a valid result.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.Y         <= '0;
    end else begin
      bus.out_valid <= s1_v;
      if (s1_v) bus.Y <= y_nxt;
    end
  end

endmodule

// File: tb/tb_approx_avg_stream.sv
// Bench for approx_avg_stream: one instance with warm-up gating, one emitting
// partial results. Drivers push expected results (value and output cycle) to
// per-instance queues; negedge monitors pop and compare.
module tb_approx_avg_stream;
  import approx_avg_pkg::*;

  localparam int W  = 9;
  localparam int SH = 3;

  localparam int Y_CONST = 225;
  localparam int Y_P90   = 11;
`ifdef APPROX_AVG_ROUND_EN
  localparam int Y_RAMP   = 113;
  localparam int Y_MAX    = 574;
  localparam int Y_ONE255 = 32;
  localparam int Y_FLUSH  = 163;
`else
  localparam int Y_RAMP   = 112;
  localparam int Y_MAX    = 573;
  localparam int Y_ONE255 = 31;
  localparam int Y_FLUSH  = 162;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rst_q = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  approx_avg_stream_if #(.DATA_W(8)) bus0 ();
  approx_avg_stream_if #(.DATA_W(8)) bus1 ();

  approx_avg_stream #(.DATA_W(8), .WIN(W), .SH(SH), .EMIT_PARTIAL(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  approx_avg_stream #(.DATA_W(8), .WIN(W), .SH(SH), .EMIT_PARTIAL(1)) dut_p (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q0 [$];
  logic [OUT_W-1:0] exp_q1 [$];
  int               cyc_q0 [$];
  int               cyc_q1 [$];
  logic [OUT_W-1:0] last_y [2];
  int               n_checks = 0;
  int               n_pass   = 0;

  // Bench-side window model per instance (index 0 = newest).
  int win_m [2][W];
  int cnt_m [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_y(input int id);
    int s, a, best, y;
    s = 0;
    best = 0;
    for (int i = 0; i < W; i++) s += win_m[id][i];
    a = s / W;
    for (int i = 0; i < W; i++)
      if (win_m[id][i] <= a && win_m[id][i] > best) best = win_m[id][i];
`ifdef APPROX_AVG_ROUND_EN
    y = (s + W * best + (1 << (SH - 1))) >> SH;
    if (y > 1023) y = 1023;
`else
    y = (s + W * best) >> SH;
`endif
    return y;
  endfunction

  function automatic void model_clear(input int id);
    for (int i = 0; i < W; i++) win_m[id][i] = 0;
    cnt_m[id] = 0;
  endfunction

  // ---------------- driver tasks ----------------
  // Present one sample for one cycle; hand >= 0 gives a hand-computed result.
  task automatic send(input int id, input int x, input bit fl, input int hand);
    int y;
    if (id == 0) begin
      bus0.in_valid = 1'b1; bus0.X = 8'(x); bus0.flush = fl;
    end else begin
      bus1.in_valid = 1'b1; bus1.X = 8'(x); bus1.flush = fl;
    end
    if (fl) model_clear(id);
    for (int i = W - 1; i > 0; i--) win_m[id][i] = win_m[id][i-1];
    win_m[id][0] = x;
    if (cnt_m[id] < W) cnt_m[id]++;
    if (id == 1 || cnt_m[id] == W) begin
      y = (hand >= 0) ? hand : model_y(id);
      if (id == 0) begin exp_q0.push_back(OUT_W'(y)); cyc_q0.push_back(cyc + 3); end
      else         begin exp_q1.push_back(OUT_W'(y)); cyc_q1.push_back(cyc + 3); end
    end
    @(posedge clk); #1;
    bus0.in_valid = 1'b0; bus0.flush = 1'b0;
    bus1.in_valid = 1'b0; bus1.flush = 1'b0;
  endtask

  task automatic flush_only(input int id);
    if (id == 0) bus0.flush = 1'b1; else bus1.flush = 1'b1;
    model_clear(id);
    @(posedge clk); #1;
    bus0.flush = 1'b0;
    bus1.flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reset both instances; anything in flight is discarded.
  task automatic do_reset(input int n);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q0.delete(); cyc_q0.delete();
    exp_q1.delete(); cyc_q1.delete();
    model_clear(0);
    model_clear(1);
    repeat (n - 1) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int id, input logic ov, input logic [OUT_W-1:0] y);
    logic [OUT_W-1:0] e;
    int               ec;
    bit               empty;
    if (rst_q) begin
      check($sformatf("reset_out_valid%0d", id), 32'(ov), 0);
      check($sformatf("reset_y%0d", id), 32'(y), 0);
      last_y[id] = '0;
    end else if (ov) begin
      empty = (id == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      n_checks++;
      if (empty) begin
        $display("FAIL unexpected_out%0d: out_valid=1 Y=%0d at cycle %0d, none expected", id, y, cyc);
      end else begin
        n_pass++;
        if (id == 0) begin e = exp_q0.pop_front(); ec = cyc_q0.pop_front(); end
        else         begin e = exp_q1.pop_front(); ec = cyc_q1.pop_front(); end
        check($sformatf("y%0d", id), 32'(y), 32'(e));
        check($sformatf("latency%0d", id), cyc, ec);
      end
      last_y[id] = y;
    end else begin
      check($sformatf("y_hold%0d", id), 32'(y), 32'(last_y[id]));
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.out_valid, bus0.Y);
    mon(1, bus1.out_valid, bus1.Y);
  end

  // ---------------- stimulus ----------------
  int gap_v [6] = '{17, 200, 3, 99, 140, 66};

  initial begin
    bus0.in_valid = 1'b0; bus0.X = '0; bus0.flush = 1'b0;
    bus1.in_valid = 1'b0; bus1.X = '0; bus1.flush = 1'b0;
    last_y[0] = '0;
    last_y[1] = '0;
    model_clear(0);
    model_clear(1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_reset_out_valid", 32'(bus0.out_valid), 0);
    check("post_reset_y", 32'(bus0.Y), 0);

    // Constant stream of 100, first output two cycles after the 9th sample.
    repeat (12) send(0, 100, 1'b0, Y_CONST);
    // Flush together with a sample of 50; earlier results still drain.
    send(0, 50, 1'b1, -1);
    repeat (7) send(0, 100, 1'b0, -1);
    send(0, 100, 1'b0, Y_FLUSH);
    idle(4);

    // Ramp 10..90.
    flush_only(0);
    for (int k = 1; k <= 9; k++) send(0, 10 * k, 1'b0, (k == 9) ? Y_RAMP : -1);
    idle(3);

    // Full-scale window, then a single 255 among zeros.
    flush_only(0);
    repeat (8) send(0, 255, 1'b0, -1);
    send(0, 255, 1'b0, Y_MAX);
    repeat (8) send(0, 0, 1'b0, -1);
    send(0, 255, 1'b0, Y_ONE255);

    // Gapped input: 1-0-0-1 pattern.
    for (int i = 0; i < 6; i++) begin
      send(0, gap_v[i], 1'b0, -1);
      idle(2);
    end
    idle(4);

    // Partial-emit instance from reset.
    do_reset(2);
    send(1, 90, 1'b0, Y_P90);
    send(1, 30, 1'b0, -1);
    send(1, 200, 1'b0, -1);
    send(1, 45, 1'b0, -1);
    send(1, 120, 1'b0, -1);
    // Mid-stream reset drops everything in flight.
    do_reset(2);
    check("mid_reset_out_valid", 32'(bus1.out_valid), 0);
    check("mid_reset_y", 32'(bus1.Y), 0);
    send(1, 90, 1'b0, Y_P90);
    idle(6);

    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/approx_avg_stream.md
Name: approx_avg_stream

Overview:
- Streaming approximate-averaging filter over a sliding window of WIN samples, DATA_W bits each.
- Per accepted sample, finds the largest window sample not exceeding the window mean ("appr"). Emits (sum + WIN*appr) >> SH.
- Adds over the fixed 9-tap generation: parametrised width/depth/scale, valid handshake, warm-up gating, synchronous flush, registered 2-cycle pipeline.
- Sits between the sample front end and downstream result logic.

Parameters:
- DATA_W, 8, sample width in bits.
- WIN, 9, window depth; legal 2..64. Constraint: WIN <= 2**(SH+1), so the output fits.
- SH, 3, output right-shift amount; legal >= 1.
- EMIT_PARTIAL, 0, 1 = emit results from the first sample with a zero-filled window; 0 = emit only once the window is full.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  X is sampled on this edge; no backpressure.
- X  in  DATA_W  input sample.
- flush  in  1  synchronous window clear.
- out_valid  out  1  Y is valid this cycle.
- Y  out  DATA_W+2  filter result.

Behaviour:
- Reset (reset=1 at a rising edge):
  - Window taps, sum, fill count, pipeline regs, Y = 0.
  - out_valid = 0.
  - Overrides in_valid and flush.
  - Mid-operation reset discards all in-flight results.
- Stage 0, on an in_valid edge:
  - Window shifts; the oldest tap drops out and X enters as the newest.
  - sum <= sum - oldest + X.
  - sum width is DATA_W + clog2(WIN) + 1.
  - fill count saturates at WIN.
  - With in_valid=0, the window, sum and count hold.
- Stage 1, registered on the edge after stage 0:
  - avg = floor(sum / WIN), constant divider, combinational.
  - appr = exact maximum of all WIN taps with tap <= avg. It always exists, because the minimum tap <= mean.
  - Registers appr, sum and a valid bit.
- Stage 2, registered on the next edge:
  - Y <= (sum + WIN*appr) >> SH, truncated (see ROUND_EN).
  - Intermediate width is DATA_W + clog2(WIN) + 2; no overflow under the WIN constraint.
  - out_valid <= stage-1 valid.
- Latency: a sample accepted at edge t gives out_valid=1 during the cycle after edge t+2.
  - Exactly one output per accepted sample, once gated in.
  - Back-to-back input gives back-to-back output; bubbles propagate unchanged.
- Gating:
  - EMIT_PARTIAL=0: the valid bit enters stage 1 only if fill count == WIN after the stage-0 update. The WIN-th accepted sample produces the first output.
  - EMIT_PARTIAL=1: every accepted sample produces an output.
- Flush:
  - Clears taps, sum and fill count. Does not kill results already in stages 1–2.
  - flush and in_valid in the same cycle: clear first, then X is loaded as the first sample (count=1, sum=X, other taps 0).
- Y holds its last value while out_valid=0.

Optional Feature:
- Macro: APPROX_AVG_ROUND_EN.
  - Defined: stage 2 adds 2**(SH-1) before the shift (round half up). The intermediate is widened by 1 bit; Y saturates at 2**(DATA_W+2)-1.
  - Undefined: plain truncating shift.

Decomposition:
- Package approx_avg_pkg:
  - clog2 function.
  - Derived-width localparams: SUM_W, ACC_W, CNT_W, OUT_W.
  - Default constants.
- Sub-module approx_sel:
  - Purely combinational log-depth reduction tree.
  - Inputs: the WIN taps and avg. Output: the largest tap <= avg.
  - Leaf rule: a tap > avg is masked to 0.
  - Instantiated once in stage 1.

Test Plan (defaults WIN=9, SH=3, DATA_W=8, EMIT_PARTIAL=0 unless stated):
- Constant stream of 100:
  - First out_valid 2 cycles after the 9th sample.
  - sum=900, avg=100, Y=225 on every later output.
- Samples 10,20,…,90:
  - sum=450, avg=50, appr=50, Y=112.
  - With APPROX_AVG_ROUND_EN: Y=113.
- Nine samples of 255 (worst case):
  - sum=2295, Y=573, no overflow.
  - Samples 0,0,0,0,0,0,0,0,255: avg=28, appr=0, Y=31.
- Gapped in_valid (1-0-0-1 pattern): outputs follow only accepted samples, each 2 cycles later, with an unchanged value sequence.
- Flush after 12 samples of 100, asserted with in_valid and X=50:
  - Results already in flight still appear.
  - No output until 8 more samples.
  - Samples 50 + 8×100: sum=850, avg=94, appr=50, Y=162.
- EMIT_PARTIAL=1 from reset, X=90:
  - out_valid appears 2 cycles later.
  - sum=90, avg=10, appr=0, Y=11.
  - reset asserted mid-stream: out_valid=0 and Y=0 on the next cycle.
